line_burst_adapter: RTL and testbench

LINE_BURST_ADAPTER -- requirements
Module: line_burst_adapter

---
 rtl/line_burst_adapter.sv | 137 +++++++++++++
 tb/tb_line_burst_adapter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/line_burst_adapter.sv
// line_burst_adapter: converts one cache-line read/write request into a burst
// of s_line/s_burst memory beats (beat 0 first, beat k = line bits of slot k).
// Optional build macro LINE_BURST_ALIGN_EN forces address_o[4:0] to zero.
//
// state | meaning
// IDLE  | waiting for read_i/write_i; read_i has priority
// READ  | read_o high, one beat stored per resp_i
// WRITE | write_o high, burst_o shows current slot, advances per resp_i
// DONE  | resp_o high for one cycle, requests ignored
module line_burst_adapter #(
    parameter int s_line  = 256,
    parameter int s_burst = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [s_line-1:0]  line_i,
    output logic [s_line-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [s_burst-1:0] burst_i,
    output logic [s_burst-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int N_BEATS = s_line / s_burst;
    localparam int CW      = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(N_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [s_line-1:0]  r_rline;
    logic [s_line-1:0]  r_wline;
    logic [31:0]        r_addr;
    logic               r_read;
    logic               r_write;
    logic               r_resp;
    logic [s_burst-1:0] r_burst;

    logic [31:0]        w_addr_cap;
    logic [CW-1:0]      w_cnt_nxt;
    logic [s_burst-1:0] w_next_beat;

`ifdef LINE_BURST_ALIGN_EN
    assign w_addr_cap = {address_i[31:5], 5'b0};
`else
    assign w_addr_cap = address_i;
`endif

    assign w_cnt_nxt   = r_cnt + 1'b1;
    assign w_next_beat = r_wline[int'(w_cnt_nxt)*s_burst +: s_burst];

    // Sequencer: state, beat counter, line buffers and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rline <= '0;
            r_wline <= '0;
            r_addr  <= '0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_resp  <= 1'b0;
            r_burst <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (read_i) begin
                        r_addr  <= w_addr_cap;
                        r_read  <= 1'b1;
                        r_state <= READ;
                    end else if (write_i) begin
                        r_addr  <= w_addr_cap;
                        r_wline <= line_i;
                        r_burst <= line_i[s_burst-1:0];
                        r_write <= 1'b1;
                        r_state <= WRITE;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        r_rline[int'(r_cnt)*s_burst +: s_burst] <= burst_i;
                        if (r_cnt == LAST_BEAT) begin
                            r_cnt   <= '0;
                            r_read  <= 1'b0;
                            r_resp  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_cnt <= w_cnt_nxt;
                        end
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        if (r_cnt == LAST_BEAT) begin
                            r_cnt   <= '0;
                            r_write <= 1'b0;
                            r_resp  <= 1'b1;
                            r_burst <= '0;
                            r_state <= DONE;
                        end else begin
                            r_cnt   <= w_cnt_nxt;
                            r_burst <= w_next_beat;
                        end
                    end
                end
                DONE: begin
                    r_resp  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign line_o    = r_rline;
    assign address_o = r_addr;
    assign read_o    = r_read;
    assign write_o   = r_write;
    assign resp_o    = r_resp;
    assign burst_o   = r_burst;

endmodule

// File: tb/tb_line_burst_adapter.sv
// Testbench for line_burst_adapter: table of directed transactions, a reset
// abort sequence, idle-strobe checks and randomized transactions, all checked
// against a transaction-level model (expected line = concatenated beats).
module tb_line_burst_adapter;

    logic         clk;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int n_tests = 0;
    int n_fail  = 0;

    logic [255:0] m_line;

    line_burst_adapter #(.s_line(256), .s_burst(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           rd;
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
        logic [15:0]  pat;
        logic [255:0] exp_line;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [31:0] exp_addr(input logic [31:0] a);
`ifdef LINE_BURST_ALIGN_EN
        return {a[31:5], 5'b0};
`else
        return a;
`endif
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One complete line transaction; resp_i follows pat (LSB first), then 1s.
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [255:0] data, input logic [15:0] pat);
        int  k;
        int  cyc;
        bit  r;
        k   = 0;
        cyc = 0;
        read_i    = rd;
        write_i   = wr;
        address_i = addr;
        line_i    = rd ? rand_line() : data;
        burst_i   = {$urandom, $urandom};
        resp_i    = 1'b0;
        tick();
        chk("start_read_o", {255'd0, read_o}, {255'd0, rd});
        chk("start_write_o", {255'd0, write_o}, {255'd0, !rd});
        chk("start_address_o", {224'd0, address_o}, {224'd0, exp_addr(addr)});
        chk("start_resp_o", {255'd0, resp_o}, 256'd0);
        line_i = rand_line();
        while (k < 4 && cyc < 64) begin
            r       = (cyc < 16) ? pat[cyc[3:0]] : 1'b1;
            resp_i  = r;
            burst_i = rd ? data[k*64 +: 64] : {$urandom, $urandom};
            chk("beat_burst_o", {192'd0, burst_o}, rd ? 256'd0 : {192'd0, data[k*64 +: 64]});
            chk("beat_busy", {254'd0, read_o, write_o}, rd ? 256'd2 : 256'd1);
            chk("beat_resp_o", {255'd0, resp_o}, 256'd0);
            tick();
            if (r) k++;
            cyc++;
        end
        if (k < 4) chk("txn_timeout", 256'(k), 256'd4);
        resp_i = 1'b0;
        if (rd) m_line = data;
        chk("done_resp_o", {255'd0, resp_o}, 256'd1);
        chk("done_busy", {254'd0, read_o, write_o}, 256'd0);
        chk("done_burst_o", {192'd0, burst_o}, 256'd0);
        chk("done_line_o", line_o, m_line);
        // requests and strobes during DONE must be ignored
        read_i  = 1'b1;
        write_i = 1'b1;
        resp_i  = 1'b1;
        tick();
        chk("idle_resp_o", {255'd0, resp_o}, 256'd0);
        chk("idle_busy", {254'd0, read_o, write_o}, 256'd0);
        chk("idle_line_o", line_o, m_line);
        read_i  = 1'b0;
        write_i = 1'b0;
        resp_i  = 1'b0;
    endtask

    initial begin
        m_line    = '0;
        rst       = 1'b1;
        line_i    = '0;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = '0;
        resp_i    = 1'b0;

        vecs[0] = '{1'b1, 1'b0, 32'h0000_1020,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                    16'hFFFF,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_2040,
                    {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                     64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                    16'h0059,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_3000,
                    {64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0002,
                     64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0000},
                    16'h5555,
                    {64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0002,
                     64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0000}};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_103F,
                    {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                     64'h0F0F_0F0F_F0F0_F0F0, 64'h5A5A_A5A5_5A5A_A5A5},
                    16'hFFFF,
                    {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                     64'h0F0F_0F0F_F0F0_F0F0, 64'h5A5A_A5A5_5A5A_A5A5}};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_103F,
                    {64'h8000_0000_0000_0004, 64'h8000_0000_0000_0003,
                     64'h8000_0000_0000_0002, 64'h8000_0000_0000_0001},
                    16'h0001,
                    {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                     64'h0F0F_0F0F_F0F0_F0F0, 64'h5A5A_A5A5_5A5A_A5A5}};

        tick();
        tick();
        chk("rst_read_o", {255'd0, read_o}, 256'd0);
        chk("rst_write_o", {255'd0, write_o}, 256'd0);
        chk("rst_resp_o", {255'd0, resp_o}, 256'd0);
        chk("rst_address_o", {224'd0, address_o}, 256'd0);
        chk("rst_line_o", line_o, 256'd0);
        chk("rst_burst_o", {192'd0, burst_o}, 256'd0);
        rst = 1'b0;

        // strobes in IDLE do nothing
        for (int i = 0; i < 3; i++) begin
            resp_i  = 1'b1;
            burst_i = {$urandom, $urandom};
            tick();
            chk("idle_strobe_busy", {253'd0, read_o, write_o, resp_o}, 256'd0);
            chk("idle_strobe_line", line_o, m_line);
        end
        resp_i = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].pat);
            chk("tbl_line_o", line_o, vecs[i].exp_line);
        end

        // reset in the middle of a read: partial burst discarded
        read_i    = 1'b1;
        address_i = 32'h0000_5000;
        tick();
        resp_i  = 1'b1;
        burst_i = 64'h9999_0000_0000_0000;
        tick();
        burst_i = 64'h9999_0000_0000_0001;
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", {253'd0, read_o, write_o, resp_o}, 256'd0);
        chk("arst_line_o", line_o, 256'd0);
        chk("arst_address_o", {224'd0, address_o}, 256'd0);
        read_i = 1'b0;
        resp_i = 1'b0;
        tick();
        rst    = 1'b0;
        m_line = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_no_resp", {253'd0, read_o, write_o, resp_o}, 256'd0);
        end
        run_txn(1'b1, 1'b0, 32'h0000_6000,
                {64'h7777_0000_0000_0003, 64'h7777_0000_0000_0002,
                 64'h7777_0000_0000_0001, 64'h7777_0000_0000_0000}, 16'hFFFF);

        // randomized transactions
        for (int i = 0; i < 24; i++) begin
            bit rd;
            bit wr;
            rd = $urandom_range(0, 1) == 1;
            wr = rd ? ($urandom_range(0, 1) == 1) : 1'b1;
            run_txn(rd, wr, $urandom, rand_line(), 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
